add_serial_param: RTL and testbench
===================================

Name: add_serial_param

Overview:
- Parametrised successor to the 8-bit bit-serial adder.
- Operand width and digit size (bits processed per cycle) are configurable.
- Adds subtract mode, carry/borrow-in, carry-out and signed overflow, a busy/done handshake and a synchronous abort.
- Sits in the datapath as a low-area multi-cycle arithmetic unit driven by a start pulse from a controller FSM.

Parameters:
- WIDTH, 8: operand and result width in bits. Must be ≥2.
- DIGIT, 1: bits processed per RUN cycle. Legal range 1..WIDTH, and WIDTH % DIGIT must be 0 (elaboration error otherwise).
- CYCLES (localparam): equals WIDTH/DIGIT, the number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = add (a+b+cin); 1 = subtract (a-b-cin)
- cin  input  1  carry-in (add) or borrow-in (subtract)
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- clr  input  1  synchronous abort
- sum  output  WIDTH  result shift register
- cout  output  1  carry-out (add) or borrow-out (subtract)
- ovf  output  1  two's-complement overflow
- busy  output  1  high while not in IDLE
- done  output  1  one-cycle pulse; result valid

Behaviour:
- Reset (rst low, async): state=IDLE; sum, cout, ovf, done, internal a/b regs, carry and count all 0. Takes effect immediately, including mid-operation. No output from an interrupted operation survives.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 and clr=0:
  - a_reg<=a; b_reg<=(op ? ~b : b); carry<=(op ? ~cin : cin).
  - sum<=0; cout<=0; ovf<=0; count<=0; op is latched; go to RUN.
- IDLE, start=0: hold all registers.
- RUN, each cycle:
  - Digit d = a_reg[DIGIT-1:0] + b_reg[DIGIT-1:0] + carry (DIGIT+1 bits).
  - sum<={d[DIGIT-1:0], sum[WIDTH-1:DIGIT]} (new digit enters at MSB end, LSB digit first).
  - carry<=d[DIGIT]; a_reg and b_reg shift right by DIGIT; count<=count+1.
- RUN, final cycle (count==CYCLES-1):
  - cout<=(latched op ? ~d[DIGIT] : d[DIGIT]).
  - ovf<=(carry into bit WIDTH-1) XOR d[DIGIT]. For DIGIT=1 the carry into bit WIDTH-1 is the carry register.
  - Go to DONE.
- DONE: done=1 for exactly this one cycle, then IDLE unconditionally. start is ignored in DONE.
- Latency: done is high in the cycle after the CYCLES-th rising edge following the start-accept edge.
- Output validity:
  - sum/cout/ovf are stable and valid from the done cycle until the next accepted start.
  - sum holds partial data during RUN and must not be consumed then.
- busy: combinational, equals (state!=IDLE).
- start while busy: ignored, with no queuing.
- clr=1 in any state: next state IDLE; sum, cout, ovf and count cleared; done not asserted.
  - clr has priority over start.
  - clr in DONE suppresses nothing already asserted; done is already high that cycle.
- Arithmetic is modulo 2^WIDTH.
- Subtract is a + ~b + ~cin. The reported borrow is the inverted final carry.
- Back-to-back operations: the earliest next accept is the first IDLE cycle after done, i.e. one op per CYCLES+2 cycles.

Test Plan:
- WIDTH=8, DIGIT=1, op=0, cin=0, a=0x5A, b=0x33 -> done 8 edges after start; sum=0x8D, cout=0, ovf=1; busy high for 9 cycles.
- WIDTH=8, DIGIT=1, op=1, cin=0, a=0x10, b=0x20 -> sum=0xF0, cout(borrow)=1, ovf=0. Repeat with a=0x80, b=0x01 -> sum=0x7F, borrow=0, ovf=1.
- WIDTH=8, DIGIT=4, op=0, a=0xFF, b=0x01, cin=0 -> done 2 edges after start; sum=0x00, cout=1, ovf=0. Also a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- WIDTH=16, DIGIT=8, op=1, cin=1, a=0x1234, b=0x0234 -> sum=0x0FFF, borrow=0, ovf=0, done after 2 RUN cycles.
- Start held high throughout an op with new a/b values -> first result unchanged and second op begins only in the IDLE cycle after done. clr pulsed mid-RUN -> IDLE next cycle, sum=0, no done pulse.
- rst driven low asynchronously mid-RUN (between edges) -> outputs 0 immediately. After release, a fresh 0x01+0x01 op gives sum=0x02, cout=0.

Source files
------------

// File: rtl/add_serial_param.sv
// add_serial_param: multi-cycle digit-serial adder/subtractor.
// A start pulse in IDLE captures both operands. The unit then adds one
// DIGIT-bit slice per cycle, beginning with the least significant slice,
// and raises done for one cycle once the result is complete.
// Subtraction is computed as a + ~b + ~cin, and the final carry is
// inverted so that cout reports a borrow.
//
// Handshake: start is sampled only while busy is low; start while busy is
// dropped, not queued. done is a single-cycle pulse. sum, cout and ovf are
// valid from the done cycle until the next accepted start. clr aborts to
// IDLE from any state and takes priority over start.
module add_serial_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active low
    input  logic             start,
    input  logic             op,         // 0 = add, 1 = subtract
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg   // current FSM state, for observation
);

    localparam int CYCLES = WIDTH / DIGIT;
    localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam int DW     = DIGIT + 1;

    // Reject parameter sets that the slice schedule cannot cover exactly.
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("add_serial_param: illegal WIDTH/DIGIT combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            op_q, op_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [DW-1:0]   digit;
    logic            msb_cin;
    logic            last;

    // Add the current slice. The carry into the top bit of the slice is
    // recovered from that bit's sum and its two operand bits. On the last
    // slice, this is the carry into bit WIDTH-1.
    always_comb begin
        digit   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + DW'(carry_q);
        msb_cin = digit[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
        last    = (cnt_q == CW'(CYCLES - 1));
    end

    // Compute the next state and the datapath updates. Every register
    // holds its value unless a branch below changes it.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        op_d    = op_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        if (clr) begin
            state_d = S_IDLE;
            sum_d   = '0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_d     = a;
                        b_d     = op ? ~b : b;
                        carry_d = op ? ~cin : cin;
                        op_d    = op;
                        sum_d   = '0;
                        cout_d  = 1'b0;
                        ovf_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    // The new slice enters at the MSB end of sum, so the
                    // first slice computed ends up at the LSB.
                    sum_d   = (sum_q >> DIGIT) | (WIDTH'(digit[DIGIT-1:0]) << (WIDTH - DIGIT));
                    carry_d = digit[DIGIT];
                    a_d     = a_q >> DIGIT;
                    b_d     = b_q >> DIGIT;
                    cnt_d   = cnt_q + CW'(1);
                    if (last) begin
                        cout_d  = op_q ^ digit[DIGIT];
                        ovf_d   = msb_cin ^ digit[DIGIT];
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers. Reset clears them immediately, so no
    // result from an interrupted operation survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Drive the outputs directly from the state and result registers.
    always_comb begin
        sum       = sum_q;
        cout      = cout_q;
        ovf       = ovf_q;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_add_serial_param.sv
// Bench for add_serial_param. It runs three instances side by side
// (8/1, 8/4 and 16/8), so every operation exercises several digit sizes.
module tb_add_serial_param;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic start = 1'b0;
    logic clr   = 1'b0;
    logic op8 = 1'b0, cin8 = 1'b0, op16 = 1'b0, cin16 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;

    logic [7:0]  s1, s4;
    logic [15:0] s16;
    logic c1, c4, c16, v1, v4, v16, bz1, bz4, bz16, dn1, dn4, dn16;
    logic [1:0] st1, st4, st16;

    add_serial_param #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .op(op8), .cin(cin8), .a(a8), .b(b8),
        .clr(clr), .sum(s1), .cout(c1), .ovf(v1), .busy(bz1), .done(dn1), .state_dbg(st1));
    add_serial_param #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start), .op(op8), .cin(cin8), .a(a8), .b(b8),
        .clr(clr), .sum(s4), .cout(c4), .ovf(v4), .busy(bz4), .done(dn4), .state_dbg(st4));
    add_serial_param #(.WIDTH(16), .DIGIT(8)) u_d16 (
        .clk(clk), .rst(rst), .start(start), .op(op16), .cin(cin16), .a(a16), .b(b16),
        .clr(clr), .sum(s16), .cout(c16), .ovf(v16), .busy(bz16), .done(dn16), .state_dbg(st16));

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic op8, cin8;
        logic [7:0] a8, b8, s8;
        logic c8, v8;
        logic op16, cin16;
        logic [15:0] a16, b16, s16;
        logic c16, v16;
    } vec_t;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input int w, input logic o, input logic ci,
                                  input longint x, input longint y,
                                  output longint s, output logic co, output logic ov);
        longint m, sx, sy, full, sv;
        m  = longint'(1) << w;
        sx = (x >= m / 2) ? x - m : x;
        sy = (y >= m / 2) ? y - m : y;
        if (!o) begin
            full = x + y + longint'(ci);
            s    = full % m;
            co   = (full >= m);
            sv   = sx + sy + longint'(ci);
        end else begin
            full = x - y - longint'(ci);
            s    = (full + m) % m;
            co   = (full < 0);
            sv   = sx - sy - longint'(ci);
        end
        ov = (sv < -(m / 2)) || (sv > m / 2 - 1);
    endfunction

    // ---------------- driver ----------------
    int lat1, lat4, lat16, bsy1;
    logic dn1_after, bz1_after;

    task automatic do_op(input vec_t v);
        @(negedge clk);
        op8 = v.op8; cin8 = v.cin8; a8 = v.a8; b8 = v.b8;
        op16 = v.op16; cin16 = v.cin16; a16 = v.a16; b16 = v.b16;
        start = 1'b1;
        lat1 = -1; lat4 = -1; lat16 = -1; bsy1 = 0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) @(negedge clk);
            if (bz1) bsy1++;
            if (dn1  && lat1  < 0) lat1  = k;
            if (dn4  && lat4  < 0) lat4  = k;
            if (dn16 && lat16 < 0) lat16 = k;
            if (lat1 >= 0 && lat4 >= 0 && lat16 >= 0) break;
        end
        @(negedge clk);
        dn1_after = dn1;
        bz1_after = bz1;
    endtask

    task automatic check_op(input string tag, input vec_t v);
        chk({tag, " lat d1"}, lat1, 8);
        chk({tag, " lat d4"}, lat4, 2);
        chk({tag, " lat d16"}, lat16, 2);
        chk({tag, " busy cycles d1"}, bsy1, 9);
        chk({tag, " done pulse d1"}, {dn1_after, bz1_after}, 0);
        chk({tag, " sum d1"}, s1, v.s8);
        chk({tag, " cout d1"}, c1, v.c8);
        chk({tag, " ovf d1"}, v1, v.v8);
        chk({tag, " sum d4"}, s4, v.s8);
        chk({tag, " cout d4"}, c4, v.c8);
        chk({tag, " ovf d4"}, v4, v.v8);
        chk({tag, " sum d16"}, s16, v.s16);
        chk({tag, " cout d16"}, c16, v.c16);
        chk({tag, " ovf d16"}, v16, v.v16);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((bz1 || bz4 || bz16) && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("idle timeout", (bz1 || bz4 || bz16), 0);
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        longint es;
        logic ec, ev;
        int seen;

        // Hand-derived vectors: {op8,cin8,a8,b8,sum8,c8,v8, op16,cin16,a16,b16,sum16,c16,v16}
        tbl[0] = '{1'b0, 1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h0234, 16'h0FFF, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};

        // Reset state
        #12;
        chk("reset sum d1", s1, 0);
        chk("reset flags d1", {c1, v1, bz1, dn1}, 0);
        chk("reset sum d16", s16, 0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i]);
            check_op($sformatf("tbl%0d", i), tbl[i]);
        end

        // Randomized vectors against the model
        for (int i = 0; i < 40; i++) begin
            rv.op8 = 1'($urandom_range(0, 1)); rv.cin8 = 1'($urandom_range(0, 1));
            rv.a8 = 8'($urandom); rv.b8 = 8'($urandom);
            rv.op16 = 1'($urandom_range(0, 1)); rv.cin16 = 1'($urandom_range(0, 1));
            rv.a16 = 16'($urandom); rv.b16 = 16'($urandom);
            model(8, rv.op8, rv.cin8, longint'(rv.a8), longint'(rv.b8), es, ec, ev);
            rv.s8 = 8'(es); rv.c8 = ec; rv.v8 = ev;
            model(16, rv.op16, rv.cin16, longint'(rv.a16), longint'(rv.b16), es, ec, ev);
            rv.s16 = 16'(es); rv.c16 = ec; rv.v16 = ev;
            do_op(rv);
            check_op($sformatf("rnd%0d", i), rv);
        end

        // Start held high with changing operands: first result intact,
        // second op accepted only in the IDLE cycle after done.
        @(negedge clk);
        op8 = 1'b0; cin8 = 1'b0; a8 = 8'h11; b8 = 8'h22; start = 1'b1;
        @(negedge clk);
        a8 = 8'h44; b8 = 8'h55;
        seen = 0;
        for (int k = 0; k < 30 && !dn1; k++) @(negedge clk);
        chk("held done seen", dn1, 1);
        chk("held first sum", s1, 8'h33);
        @(negedge clk);
        chk("held idle gap busy", bz1, 0);
        chk("held sum after done", s1, 8'h33);
        @(negedge clk);
        chk("held second accept", bz1, 1);
        start = 1'b0;
        for (int k = 0; k < 30 && !dn1; k++) @(negedge clk);
        chk("held second done", dn1, 1);
        chk("held second sum", s1, 8'h99);
        wait_idle();

        // clr mid-RUN: back to IDLE, results cleared, no done
        @(negedge clk);
        op8 = 1'b0; cin8 = 1'b0; a8 = 8'hFF; b8 = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr busy d1", bz1, 0);
        chk("clr state d1", st1, 0);
        chk("clr sum d1", s1, 0);
        chk("clr flags d1", {c1, v1, dn1}, 0);
        chk("clr sum d4 idle", s4, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (dn1) seen = 1;
        end
        chk("clr no done", seen, 0);

        // Asynchronous reset between edges mid-RUN
        @(negedge clk);
        op8 = 1'b0; cin8 = 1'b0; a8 = 8'hFF; b8 = 8'h00;
        op16 = 1'b0; cin16 = 1'b0; a16 = 16'hFFFF; b16 = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-rst sum d4", s4, 8'hFF);
        #1 rst = 1'b0;
        #1;
        chk("rst sum d1", s1, 0);
        chk("rst busy d1", bz1, 0);
        chk("rst sum d4", s4, 0);
        chk("rst sum d16", s16, 0);
        @(negedge clk);
        rst = 1'b1;
        rv = '{1'b0, 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0};
        do_op(rv);
        check_op("post-rst", rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
